// File: rtl/ecc_44_rd_check.sv
// Read-side check stage after the SEC-DED decoder: two-entry skid buffer, 1-cycle latency,
// in_rdy registered and drops only when both entries are full; tracks error stats, first error, irq.
module ecc_44_rd_check #(
  parameter int DATA_WIDTH = 44,
  parameter int ADDR_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_vld,
  output logic                  in_rdy,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic                  in_sbit_err,
  input  logic                  in_dbit_err,
  output logic                  out_vld,
  input  logic                  out_rdy,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_dbit,
  output logic [CNT_WIDTH-1:0]  sbit_cnt,
  output logic [CNT_WIDTH-1:0]  dbit_cnt,
  output logic                  first_err_vld,
  output logic [ADDR_WIDTH-1:0] first_err_addr,
  output logic                  first_err_dbit,
  output logic                  err_irq,
  input  logic                  err_clr
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t                state_q, state_d;
  logic                  in_rdy_q, in_rdy_d;
  logic [DATA_WIDTH-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
  logic                  main_dbit_q, main_dbit_d, skid_dbit_q, skid_dbit_d;
  logic [CNT_WIDTH-1:0]  sbit_cnt_q, sbit_cnt_d, dbit_cnt_q, dbit_cnt_d;
  logic [CNT_WIDTH-1:0]  sbit_base, dbit_base;
  logic                  fe_vld_q, fe_vld_d, fe_dbit_q, fe_dbit_d, irq_q, irq_d;
  logic [ADDR_WIDTH-1:0] fe_addr_q, fe_addr_d;
  logic                  accept, transfer, dbit_ev, sbit_ev, any_ev;

  assign accept   = in_vld & in_rdy_q;
  assign transfer = (state_q != EMPTY) & out_rdy;
  // A word flagged both ways is uncorrectable; it counts only as dbit.
  assign dbit_ev  = accept & in_dbit_err;
  assign sbit_ev  = accept & in_sbit_err & ~in_dbit_err;
  assign any_ev   = dbit_ev | sbit_ev;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_dbit_d = main_dbit_q;
    skid_data_d = skid_data_q;
    skid_dbit_d = skid_dbit_q;
    case (state_q)
      EMPTY: if (accept) begin
        main_data_d = in_data;
        main_dbit_d = in_dbit_err;
        state_d     = ONE;
      end
      ONE: begin
        if (accept && transfer) begin
          main_data_d = in_data;
          main_dbit_d = in_dbit_err;
        end else if (accept) begin
          skid_data_d = in_data;
          skid_dbit_d = in_dbit_err;
          state_d     = TWO;
        end else if (transfer) begin
          state_d = EMPTY;
        end
      end
      TWO: if (transfer) begin
        main_data_d = skid_data_q;
        main_dbit_d = skid_dbit_q;
        state_d     = ONE;
      end
      default: state_d = EMPTY;
    endcase
    in_rdy_d = (state_d != TWO);
  end

  // Clear is applied before the same-cycle event so the event survives the clear.
  always_comb begin
    sbit_base  = err_clr ? '0 : sbit_cnt_q;
    dbit_base  = err_clr ? '0 : dbit_cnt_q;
    sbit_cnt_d = sbit_base;
    dbit_cnt_d = dbit_base;
    if (sbit_ev && sbit_base != CNT_MAX) sbit_cnt_d = sbit_base + CNT_ONE;
    if (dbit_ev && dbit_base != CNT_MAX) dbit_cnt_d = dbit_base + CNT_ONE;
    fe_vld_d  = err_clr ? 1'b0 : fe_vld_q;
    fe_addr_d = err_clr ? '0 : fe_addr_q;
    fe_dbit_d = err_clr ? 1'b0 : fe_dbit_q;
    if (any_ev && !fe_vld_d) begin
      fe_vld_d  = 1'b1;
      fe_addr_d = in_addr;
      fe_dbit_d = dbit_ev;
    end
    irq_d = (err_clr ? 1'b0 : irq_q) | any_ev;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      in_rdy_q    <= 1'b0;
      main_data_q <= '0;
      main_dbit_q <= 1'b0;
      skid_data_q <= '0;
      skid_dbit_q <= 1'b0;
      sbit_cnt_q  <= '0;
      dbit_cnt_q  <= '0;
      fe_vld_q    <= 1'b0;
      fe_addr_q   <= '0;
      fe_dbit_q   <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_rdy_q    <= in_rdy_d;
      main_data_q <= main_data_d;
      main_dbit_q <= main_dbit_d;
      skid_data_q <= skid_data_d;
      skid_dbit_q <= skid_dbit_d;
      sbit_cnt_q  <= sbit_cnt_d;
      dbit_cnt_q  <= dbit_cnt_d;
      fe_vld_q    <= fe_vld_d;
      fe_addr_q   <= fe_addr_d;
      fe_dbit_q   <= fe_dbit_d;
      irq_q       <= irq_d;
    end
  end

  assign in_rdy         = in_rdy_q;
  assign out_vld        = (state_q != EMPTY);
  assign out_data       = main_data_q;
  assign out_dbit       = main_dbit_q;
  assign sbit_cnt       = sbit_cnt_q;
  assign dbit_cnt       = dbit_cnt_q;
  assign first_err_vld  = fe_vld_q;
  assign first_err_addr = fe_addr_q;
  assign first_err_dbit = fe_dbit_q;
  assign err_irq        = irq_q;

endmodule

// File: tb/tb_ecc_44_rd_check.sv
// Bench for ecc_44_rd_check: directed scenarios plus random traffic against a queue-based model.
module tb_ecc_44_rd_check;

  localparam int DW = 44;
  localparam int AW = 8;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_vld = 1'b0, in_sbit_err = 1'b0, in_dbit_err = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [AW-1:0] in_addr = '0;
  logic          out_rdy = 1'b0, err_clr = 1'b0;
  logic          in_rdy, out_vld, out_dbit, first_err_vld, first_err_dbit, err_irq;
  logic [DW-1:0] out_data;
  logic [CW-1:0] sbit_cnt, dbit_cnt;
  logic [AW-1:0] first_err_addr;

  ecc_44_rd_check #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .in_vld(in_vld), .in_rdy(in_rdy), .in_data(in_data), .in_addr(in_addr),
    .in_sbit_err(in_sbit_err), .in_dbit_err(in_dbit_err),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data), .out_dbit(out_dbit),
    .sbit_cnt(sbit_cnt), .dbit_cnt(dbit_cnt),
    .first_err_vld(first_err_vld), .first_err_addr(first_err_addr),
    .first_err_dbit(first_err_dbit), .err_irq(err_irq), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          dbit;
  } word_t;

  word_t         mq[$];
  word_t         m_last;
  logic          m_rdy;
  int            m_sc, m_dc;
  logic          m_fv, m_fd, m_irq;
  logic [AW-1:0] m_fa;
  int            vectors = 0;
  int            miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_last = '0;
    m_rdy  = 1'b0;
    m_sc = 0; m_dc = 0;
    m_fv = 1'b0; m_fa = '0; m_fd = 1'b0; m_irq = 1'b0;
  endtask

  // Behavioural view: the buffer is just a FIFO of at most two words.
  task automatic model_step();
    bit acc, xfer, is_d, is_s;
    if (rst) begin
      model_reset();
      return;
    end
    acc  = in_vld && m_rdy;
    xfer = (mq.size() > 0) && out_rdy;
    if (xfer) void'(mq.pop_front());
    if (acc) mq.push_back('{d: in_data, dbit: in_dbit_err});
    if (mq.size() > 0) m_last = mq[0];
    m_rdy = (mq.size() < 2);
    if (err_clr) begin
      m_sc = 0; m_dc = 0; m_fv = 1'b0; m_fa = '0; m_fd = 1'b0; m_irq = 1'b0;
    end
    is_d = acc && in_dbit_err;
    is_s = acc && in_sbit_err && !in_dbit_err;
    if (is_s && m_sc < CMAX) m_sc++;
    if (is_d && m_dc < CMAX) m_dc++;
    if ((is_s || is_d) && !m_fv) begin
      m_fv = 1'b1; m_fa = in_addr; m_fd = is_d;
    end
    if (is_s || is_d) m_irq = 1'b1;
  endtask

  task automatic compare();
    chk("in_rdy", 64'(in_rdy), 64'(m_rdy));
    chk("out_vld", 64'(out_vld), 64'(mq.size() > 0));
    chk("out_data", 64'(out_data), 64'(m_last.d));
    chk("out_dbit", 64'(out_dbit), 64'(m_last.dbit));
    chk("sbit_cnt", 64'(sbit_cnt), 64'(m_sc));
    chk("dbit_cnt", 64'(dbit_cnt), 64'(m_dc));
    chk("first_err_vld", 64'(first_err_vld), 64'(m_fv));
    chk("first_err_addr", 64'(first_err_addr), 64'(m_fa));
    chk("first_err_dbit", 64'(first_err_dbit), 64'(m_fd));
    chk("err_irq", 64'(err_irq), 64'(m_irq));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic [AW-1:0] a,
                       input logic s, input logic db);
    in_vld = v; in_data = d; in_addr = a; in_sbit_err = s; in_dbit_err = db;
  endtask

  task automatic idle_drain(input int n);
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    out_rdy = 1'b1;
    err_clr = 1'b0;
    repeat (n) cycle();
  endtask

  initial begin
    model_reset();
    rst = 1'b1;
    repeat (2) cycle();
    chk("lit_rst_in_rdy", 64'(in_rdy), 64'd0);
    chk("lit_rst_out_vld", 64'(out_vld), 64'd0);
    chk("lit_rst_out_data", 64'(out_data), 64'd0);
    rst = 1'b0;
    cycle();
    chk("lit_rdy_after_rst", 64'(in_rdy), 64'd1);

    // Eight clean words streamed at full rate.
    out_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, DW'(64'h100 + i), AW'(i), 1'b0, 1'b0);
      cycle();
      chk("lit_stream_data", 64'(out_data), 64'h100 + 64'(i));
    end
    idle_drain(2);
    chk("lit_stream_cnt", 64'(sbit_cnt) + 64'(dbit_cnt), 64'd0);
    chk("lit_stream_irq", 64'(err_irq), 64'd0);

    // Backpressure: four offered, two held.
    out_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, DW'(64'hA00 + i), '0, 1'b0, 1'b0);
      cycle();
      if (i == 1) chk("lit_bp_rdy_low", 64'(in_rdy), 64'd0);
    end
    chk("lit_bp_hold_data", 64'(out_data), 64'hA00);
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    out_rdy = 1'b1;
    cycle();
    chk("lit_bp_second", 64'(out_data), 64'hA01);
    cycle();
    chk("lit_bp_empty", 64'(out_vld), 64'd0);

    // sbit at 0x12 then dbit at 0x34.
    drive(1'b1, DW'(64'h5A5), 8'h12, 1'b1, 1'b0);
    cycle();
    drive(1'b1, DW'(64'h6B6), 8'h34, 1'b0, 1'b1);
    cycle();
    chk("lit_err_out_dbit", 64'(out_dbit), 64'd1);
    chk("lit_err_sbit_cnt", 64'(sbit_cnt), 64'd1);
    chk("lit_err_dbit_cnt", 64'(dbit_cnt), 64'd1);
    chk("lit_err_addr", 64'(first_err_addr), 64'h12);
    chk("lit_err_type", 64'(first_err_dbit), 64'd0);
    chk("lit_err_irq", 64'(err_irq), 64'd1);

    // Saturation with a 4-bit counter.
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, DW'(i), AW'(i), 1'b1, 1'b0);
      cycle();
    end
    chk("lit_sat_sbit", 64'(sbit_cnt), 64'd15);

    // Clear coinciding with an accepted dbit.
    drive(1'b1, DW'(64'h777), 8'h55, 1'b0, 1'b1);
    err_clr = 1'b1;
    cycle();
    err_clr = 1'b0;
    chk("lit_clr_sbit", 64'(sbit_cnt), 64'd0);
    chk("lit_clr_dbit", 64'(dbit_cnt), 64'd1);
    chk("lit_clr_addr", 64'(first_err_addr), 64'h55);
    chk("lit_clr_type", 64'(first_err_dbit), 64'd1);
    chk("lit_clr_irq", 64'(err_irq), 64'd1);

    // Reset while both entries are full.
    idle_drain(2);
    out_rdy = 1'b0;
    drive(1'b1, DW'(64'hB0), 8'h9, 1'b1, 1'b0);
    repeat (2) cycle();
    chk("lit_two_rdy", 64'(in_rdy), 64'd0);
    rst = 1'b1;
    cycle();
    chk("lit_rst2_vld", 64'(out_vld), 64'd0);
    chk("lit_rst2_cnt", 64'(sbit_cnt), 64'd0);
    chk("lit_rst2_fe", 64'(first_err_vld), 64'd0);
    rst = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    cycle();
    chk("lit_rst2_rdy", 64'(in_rdy), 64'd1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      in_vld      = ($urandom_range(0, 3) != 0);
      in_data     = DW'({$urandom(), $urandom()});
      in_addr     = AW'($urandom());
      in_sbit_err = ($urandom_range(0, 3) == 0);
      in_dbit_err = ($urandom_range(0, 6) == 0);
      out_rdy     = ($urandom_range(0, 2) != 0);
      err_clr     = ($urandom_range(0, 40) == 0);
      rst         = ($urandom_range(0, 150) == 0);
      cycle();
    end
    rst = 1'b0;
    idle_drain(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ecc_44_rd_check.md
# ecc_44_rd_check

Read-side check stage directly downstream of the 44-bit SEC-DED decoder in the FIFO read path. It accepts corrected read words with their single/double-bit error flags and source address on a valid/ready interface and forwards them through a two-entry skid buffer with registered outputs. On the way through it keeps saturating error statistics, captures the address and type of the first error, and raises a sticky interrupt.

## Interface
Parameters:
- DATA_WIDTH, 44, width of corrected data word (matches decoder data_out)
- ADDR_WIDTH, 8, FIFO read address width carried alongside data
- CNT_WIDTH, 16, width of each saturating error counter

Ports:
- clk  input  1  single clock, all logic rising-edge
- rst  input  1  synchronous, active-high reset
- in_vld  input  1  upstream word valid
- in_rdy  output  1  stage can accept a word
- in_data  input  DATA_WIDTH  corrected data from decoder
- in_addr  input  ADDR_WIDTH  FIFO address the word was read from
- in_sbit_err  input  1  decoder single-bit (corrected) flag
- in_dbit_err  input  1  decoder double-bit (uncorrectable) flag
- out_vld  output  1  downstream word valid
- out_rdy  input  1  downstream accepts
- out_data  output  DATA_WIDTH  forwarded data
- out_dbit  output  1  forwarded word is uncorrectable
- sbit_cnt  output  CNT_WIDTH  accepted single-bit error count, saturating
- dbit_cnt  output  CNT_WIDTH  accepted double-bit error count, saturating
- first_err_vld  output  1  first-error capture valid
- first_err_addr  output  ADDR_WIDTH  address of first captured error
- first_err_dbit  output  1  captured error was double-bit
- err_irq  output  1  sticky, set on any accepted error
- err_clr  input  1  one-cycle pulse clearing counters, capture, irq

## Operation
- Accept event: in_vld & in_rdy. Transfer event: out_vld & out_rdy.
- Buffer FSM, states EMPTY, ONE, TWO (main register + skid register):
  - EMPTY: accept -> ONE (word into main).
  - ONE: accept & !transfer -> TWO (word into skid); transfer & !accept -> EMPTY; both -> ONE (new word into main).
  - TWO: transfer -> ONE (skid moves to main); no accept possible.
- in_rdy = state != TWO, driven from a register (no combinational path from out_rdy). out_vld = state != EMPTY. out_data/out_dbit always from main register.
- Words are forwarded unmodified in order; dbit words are passed, not dropped, with out_dbit=1.
- If both in_sbit_err and in_dbit_err are high, treat as dbit only.
- Statistics update only on accept events: sbit_cnt += 1 on sbit, dbit_cnt += 1 on dbit; each holds at 2^CNT_WIDTH-1.
- First-error capture: on an accepted error with first_err_vld=0, load in_addr and dbit type, set first_err_vld. Later errors do not overwrite.
- err_irq sets on any accepted error; stays until err_clr or rst.
- err_clr same cycle as an accepted error: clear applies first, then the event: counter for that type becomes 1, other 0; capture loads the new event; err_irq=1.
- err_clr does not affect the data path or buffer state.

## Timing
- Reset values: in_rdy=0 during rst, 1 on first cycle after; out_vld=0; out_data=0; out_dbit=0; sbit_cnt=dbit_cnt=0; first_err_vld=0; first_err_addr=0; first_err_dbit=0; err_irq=0; FSM EMPTY.
- Latency: word accepted at edge N appears on out_* after edge N (visible cycle N+1).
- Throughput: one word per cycle sustained with out_rdy=1.
- out_rdy low: at most two words held; in_rdy deasserts the cycle after the second accept.
- out_data/out_vld stable while out_vld=1 and out_rdy=0.
- Counters, capture, err_irq visible the cycle after the accept.
- rst mid-transfer: buffered words discarded, all outputs to reset values next cycle.

## Test plan
- Stream 8 clean words, out_rdy=1 -> out_data matches in order with 1-cycle latency, counters 0, err_irq=0.
- out_rdy=0 with in_vld=1 for 4 cycles -> exactly 2 accepted, in_rdy=0 from cycle 3; release out_rdy -> both words emerge in order, no loss or duplication.
- Accept sbit at addr 0x12, then dbit at addr 0x34 -> sbit_cnt=1, dbit_cnt=1, first_err_addr=0x12, first_err_dbit=0, err_irq=1, second word out_dbit=1.
- CNT_WIDTH=4, 20 accepted sbit words -> sbit_cnt saturates at 15.
- err_clr pulsed on same cycle as accepted dbit at addr 0x55 -> sbit_cnt=0, dbit_cnt=1, first_err_addr=0x55, first_err_dbit=1, err_irq=1.
- rst asserted with state TWO -> next cycle out_vld=0, all counters/capture 0, FSM EMPTY; in_rdy=1 after rst drops.
